pencoder_iter: RTL and testbench
================================

// Module: pencoder_iter
// PURPOSE
//   Iterative, handshaked, multi-lane priority encoder: the sequential successor of pencoder.
//   Accepts a WIDTH-bit request vector, then emits the index of every set bit, up to LANES per beat.
//   Emits in priority order (LSB- or MSB-first) until the vector is exhausted.
//   Used wherever all set bits must be walked (free-list / ready-mask scan) rather than only the first.
// PARAMETERS
//   WIDTH     127  request vector width, >=2, need not be a power of two
//   LANES     1    indices emitted per output beat, 1..WIDTH
//   MSB_FIRST 0    0: lowest set index has priority; 1: highest set index has priority
//   IW = $clog2(WIDTH) (localparam) index width
// PORTS
//   clk          in   1         clock, all state on rising edge
//   rst_n        in   1         asynchronous active-low reset
//   flush        in   1         synchronous abort of current scan
//   in_valid     in   1         request vector valid
//   in_ready     out  1         block can accept a vector
//   in_vec       in   WIDTH     request vector
//   out_valid    out  1         output beat valid
//   out_ready    in   1         consumer accepts beat
//   out_lane_vld out  LANES     per-lane index valid; lane 0 = highest priority
//   out_idx      out  LANES*IW  lane i index at [i*IW +: IW]
//   out_last     out  1         final beat for this vector
//   out_zero     out  1         vector was all zeros (only beat, no lanes valid)
// BEHAVIOUR
//   - Reset (async assert, sync release): state=IDLE, rem=0, out_valid=0, in_ready=1, all outputs 0.
//     Asserting reset mid-scan drops out_valid immediately; the scan is lost.
//   - FSM IDLE -> SCAN on in_valid&&in_ready. rem<=in_vec, zflag<=(in_vec==0).
//     The first beat is valid the next cycle (1-cycle latency).
//   - SCAN: out_valid=1.
//     Lanes are the first LANES set bits of rem in priority order, lane 0 first.
//     Unused lanes: lane_vld=0, idx=0. Outputs are held stable while out_ready=0.
//   - out_last = (popcount(rem) <= LANES). out_zero = zflag.
//     A zero vector yields exactly one beat: lane_vld=0, last=1, zero=1.
//   - On out_valid&&out_ready, the bits of the emitted lanes are cleared from rem.
//     If out_last: go to IDLE, unless a new vector is accepted in the same cycle.
//   - in_ready = IDLE || (out_valid && out_ready && out_last).
//     This allows back-to-back vectors with no bubble. A vector accepted on the last beat loads rem directly.
//   - Indices only ever address bits < WIDTH. Bits of the pow2 padding region never appear.
//   - flush (priority below reset, above everything else): next cycle state=IDLE, rem=0, out_valid=0.
//     A vector offered in the flush cycle is not accepted (in_ready forced 0 while flush=1).
//   - in_vec is sampled only on accept; changes on in_vec while in SCAN have no effect.
//   - Throughput: ceil(popcount/LANES) beats per vector (1 if zero).
//     Implementation must not take extra cycles per beat.
// TESTING
//   1. WIDTH=127, LANES=1, in_vec = bits{96,97,100}
//      -> beats idx 96, 97, 100; last only on 100; zero=0.
//   2. in_vec=0 -> one beat, lane_vld=0, last=1, zero=1; in_ready=1 the cycle after the handshake.
//   3. WIDTH=8, LANES=4, in_vec=8'hFF
//      -> beat {0,1,2,3} last=0, beat {4,5,6,7} last=1; 8'h07 -> one beat, lane_vld=4'b0111, idx {0,1,2,0}.
//   4. WIDTH=127, MSB_FIRST=1, in_vec = bits{0,126}
//      -> idx 126 then 0; hold out_ready=0 for 3 cycles; beat is unchanged throughout.
//   5. Back-to-back: second vector presented during the last beat with out_ready=1
//      -> accepted the same cycle, its first beat the next cycle, no gap.
//   6. Mid-scan of bits{5,9,20}: flush after the first beat -> out_valid=0 next cycle, in_ready=1.
//      Repeat with rst_n low -> out_valid=0 immediately.

Source files
------------

// File: rtl/pencoder_iter.sv
// Iterative multi-lane priority encoder: accepts a request vector and walks every set bit,
// emitting up to LANES indices per handshaked output beat in LSB- or MSB-first priority order.
module pencoder_iter #(
    parameter int WIDTH     = 127,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_vec,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES-1:0]               out_lane_vld,
    output logic [LANES*$clog2(WIDTH)-1:0] out_idx,
    output logic                           out_last,
    output logic                           out_zero,
    output logic                           dbg_scan
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_e;

    // Handshakes: a transfer on either side happens on a rising edge where valid && ready;
    // out_* are held stable while out_valid && !out_ready, and in_vec is sampled only on accept.

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             zflag_q, zflag_d;

    logic [WIDTH-1:0]    scan;
    logic [WIDTH-1:0]    emit_mask;
    logic [LANES-1:0]    lane_vld;
    logic [LANES*IW-1:0] lane_idx;
    logic                found;
    logic [IW-1:0]       pos;
    logic [IW-1:0]       bi;
    logic                last_beat;
    logic                scanning;
    logic                fire;
    logic                accept;

    // Peel off the LANES highest-priority set bits; what remains decides out_last.
    always_comb begin
        scan      = rem_q;
        emit_mask = '0;
        lane_vld  = '0;
        lane_idx  = '0;
        found     = 1'b0;
        pos       = '0;
        bi        = '0;
        for (int l = 0; l < LANES; l++) begin
            found = 1'b0;
            pos   = '0;
            for (int k = 0; k < WIDTH; k++) begin
                bi = MSB_FIRST ? IW'(WIDTH - 1 - k) : IW'(k);
                if (!found && scan[bi]) begin
                    found = 1'b1;
                    pos   = bi;
                end
            end
            if (found) begin
                lane_vld[l]             = 1'b1;
                lane_idx[l*IW +: IW]    = pos;
                scan[pos]               = 1'b0;
                emit_mask[pos]          = 1'b1;
            end
        end
        last_beat = (scan == '0);
    end

    assign scanning = (state_q == SCAN);
    assign fire     = scanning && out_ready;
    assign in_ready = !flush && (!scanning || (fire && last_beat));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        zflag_d = zflag_q;
        if (flush) begin
            state_d = IDLE;
            rem_d   = '0;
            zflag_d = 1'b0;
        end else begin
            if (fire) begin
                rem_d = rem_q & ~emit_mask;
                if (last_beat) begin
                    state_d = IDLE;
                    zflag_d = 1'b0;
                end
            end
            // A vector accepted on the final beat reloads rem directly, giving no bubble.
            if (accept) begin
                state_d = SCAN;
                rem_d   = in_vec;
                zflag_d = (in_vec == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            zflag_q <= zflag_d;
        end
    end

    assign out_valid    = scanning;
    assign out_lane_vld = scanning ? lane_vld : '0;
    assign out_idx      = scanning ? lane_idx : '0;
    assign out_last     = scanning && last_beat;
    assign out_zero     = scanning && zflag_q;
    assign dbg_scan     = scanning;

endmodule

// File: tb/tb_pencoder_iter.sv
// Bench for pencoder_iter: three configurations share stimulus; a scoreboard queue holds
// expected beats built from an independent bit-walk model and a negedge monitor pops them.
module tb_pencoder_iter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid_s = 1'b0;
    logic         out_ready_s = 1'b0;
    logic [126:0] in_vec_s = '0;
    int           sel = 0;
    bit           rand_rdy = 1'b0;
    int           n_checks = 0;
    int           n_pass = 0;
    logic [31:0]  exp_q[$];
    logic [31:0]  e;

    logic iv0, ir0, ov0, ol0, oz0, d0;
    logic [0:0] lv0;
    logic [6:0] ix0;
    logic iv1, ir1, ov1, ol1, oz1, d1;
    logic [3:0]  lv1;
    logic [11:0] ix1;
    logic iv2, ir2, ov2, ol2, oz2, d2;
    logic [0:0] lv2;
    logic [6:0] ix2;

    logic        obs_valid, obs_in_ready, obs_dbg;
    logic [31:0] obs_beat;

    always #5 clk = ~clk;

    assign iv0 = in_valid_s && (sel == 0);
    assign iv1 = in_valid_s && (sel == 1);
    assign iv2 = in_valid_s && (sel == 2);

    pencoder_iter #(.WIDTH(127), .LANES(1), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv0), .in_ready(ir0),
        .in_vec(in_vec_s), .out_valid(ov0), .out_ready(out_ready_s), .out_lane_vld(lv0),
        .out_idx(ix0), .out_last(ol0), .out_zero(oz0), .dbg_scan(d0));

    pencoder_iter #(.WIDTH(8), .LANES(4), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv1), .in_ready(ir1),
        .in_vec(in_vec_s[7:0]), .out_valid(ov1), .out_ready(out_ready_s), .out_lane_vld(lv1),
        .out_idx(ix1), .out_last(ol1), .out_zero(oz1), .dbg_scan(d1));

    pencoder_iter #(.WIDTH(127), .LANES(1), .MSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(iv2), .in_ready(ir2),
        .in_vec(in_vec_s), .out_valid(ov2), .out_ready(out_ready_s), .out_lane_vld(lv2),
        .out_idx(ix2), .out_last(ol2), .out_zero(oz2), .dbg_scan(d2));

    always_comb begin
        obs_valid    = 1'b0;
        obs_in_ready = 1'b0;
        obs_dbg      = 1'b0;
        obs_beat     = '0;
        case (sel)
            0: begin obs_valid = ov0; obs_in_ready = ir0; obs_dbg = d0; obs_beat = 32'({oz0, ol0, lv0, ix0}); end
            1: begin obs_valid = ov1; obs_in_ready = ir1; obs_dbg = d1; obs_beat = 32'({oz1, ol1, lv1, ix1}); end
            default: begin obs_valid = ov2; obs_in_ready = ir2; obs_dbg = d2; obs_beat = 32'({oz2, ol2, lv2, ix2}); end
        endcase
    end

    // Beat packing: {zero, last, lane_vld[L], idx[L*IW]} zero-extended to 32 bits.
    function automatic void push_exp(input logic [126:0] vec);
        int w, l, iw, msb, b;
        int ids[$];
        logic [6:0] bsel;
        logic [31:0] beat;
        w = (sel == 1) ? 8 : 127;
        l = (sel == 1) ? 4 : 1;
        iw = (sel == 1) ? 3 : 7;
        msb = (sel == 2) ? 1 : 0;
        for (int k = 0; k < w; k++) begin
            b = (msb != 0) ? (w - 1 - k) : k;
            bsel = 7'(b);
            if (vec[bsel]) ids.push_back(b);
        end
        if (ids.size() == 0) begin
            exp_q.push_back((32'd1 << (l*iw + l + 1)) | (32'd1 << (l*iw + l)));
        end else begin
            for (int s = 0; s < ids.size(); s += l) begin
                beat = '0;
                for (int j = 0; j < l; j++) begin
                    if (s + j < ids.size()) begin
                        beat = beat | (32'(ids[s+j]) << (j*iw)) | (32'd1 << (l*iw + j));
                    end
                end
                if (s + l >= ids.size()) beat = beat | (32'd1 << (l*iw + l));
                exp_q.push_back(beat);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n && obs_valid && out_ready_s) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_beat sel=%0d got=%h required=none", sel, obs_beat);
            end else begin
                e = exp_q.pop_front();
                if (obs_beat !== e) $display("FAIL beat sel=%0d got=%h required=%h", sel, obs_beat, e);
                else n_pass++;
            end
        end
    end

    task automatic send(input logic [126:0] vec, output int cyc);
        bit acc;
        acc = 1'b0;
        cyc = 0;
        push_exp(vec);
        in_valid_s = 1'b1;
        in_vec_s = vec;
        for (int c = 0; c < 200 && !acc; c++) begin
            if (rand_rdy) out_ready_s = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = obs_in_ready;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid_s = 1'b0;
        in_vec_s = 127'({$urandom, $urandom, $urandom, $urandom});
        if (!acc) begin
            n_checks++;
            $display("FAIL accept_timeout sel=%0d got=no_accept required=accept", sel);
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            if (rand_rdy) out_ready_s = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (exp_q.size() == 0 && !obs_valid) done = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (done) n_pass++;
        else $display("FAIL drain sel=%0d got=%0d_left required=0_left", sel, exp_q.size());
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            n_checks++;
            if (obs_valid !== 1'b0 || obs_dbg !== 1'b0) $display("FAIL reset_valid sel=%0d got=%b required=0", s, obs_valid);
            else n_pass++;
            n_checks++;
            if (obs_in_ready !== 1'b1) $display("FAIL reset_in_ready sel=%0d got=%b required=1", s, obs_in_ready);
            else n_pass++;
            n_checks++;
            if (obs_beat !== 32'd0) $display("FAIL reset_outputs sel=%0d got=%h required=0", s, obs_beat);
            else n_pass++;
        end
        sel = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lsb_first();
        logic [126:0] v;
        int cyc;
        sel = 0;
        out_ready_s = 1'b1;
        v = '0;
        v[96] = 1'b1;
        v[97] = 1'b1;
        v[100] = 1'b1;
        send(v, cyc);
        @(negedge clk);
        n_checks++;
        if (obs_in_ready !== 1'b0) $display("FAIL lsb_in_ready_mid got=%b required=0", obs_in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        wait_idle();
    endtask

    task automatic test_zero();
        int cyc;
        sel = 0;
        out_ready_s = 1'b1;
        send('0, cyc);
        @(negedge clk);
        n_checks++;
        if (obs_beat !== 32'h300) $display("FAIL zero_beat got=%h required=300", obs_beat);
        else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (obs_in_ready !== 1'b1 || obs_valid !== 1'b0)
            $display("FAIL zero_after got=rdy%b_vld%b required=rdy1_vld0", obs_in_ready, obs_valid);
        else n_pass++;
        @(posedge clk);
        #1;
        wait_idle();
    endtask

    task automatic test_lanes();
        int cyc;
        sel = 1;
        out_ready_s = 1'b1;
        send(127'h0ff, cyc);
        @(negedge clk);
        n_checks++;
        if (obs_beat[15:12] !== 4'hf || obs_beat[16] !== 1'b0)
            $display("FAIL lanes_first got=%h required=vld_f_last_0", obs_beat);
        else n_pass++;
        @(posedge clk);
        #1;
        wait_idle();
        send(127'h007, cyc);
        wait_idle();
    endtask

    task automatic test_msb_hold();
        logic [126:0] v;
        int cyc;
        sel = 2;
        out_ready_s = 1'b0;
        v = '0;
        v[0] = 1'b1;
        v[126] = 1'b1;
        send(v, cyc);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs_valid !== 1'b1 || obs_dbg !== 1'b1 || obs_beat !== 32'd254)
                $display("FAIL msb_hold cyc=%0d got=%b_%h required=1_fe", c, obs_valid, obs_beat);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        out_ready_s = 1'b1;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int cyc;
        sel = 0;
        out_ready_s = 1'b1;
        send(127'h6, cyc);
        send(127'h8, cyc);
        n_checks++;
        if (cyc !== 2) $display("FAIL b2b_accept_cycle got=%0d required=2", cyc);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs_valid !== 1'b1 || obs_beat !== 32'd387)
            $display("FAIL b2b_no_gap got=%b_%h required=1_183", obs_valid, obs_beat);
        else n_pass++;
        @(posedge clk);
        #1;
        wait_idle();
    endtask

    task automatic test_random();
        int cyc;
        logic [126:0] v;
        rand_rdy = 1'b1;
        sel = 1;
        for (int i = 0; i < 14; i++) begin
            v = ($urandom_range(0, 4) == 0) ? '0 : 127'($urandom_range(0, 255));
            send(v, cyc);
        end
        wait_idle();
        for (int s = 0; s < 3; s += 2) begin
            sel = s;
            for (int i = 0; i < 5; i++) begin
                v = 127'({$urandom, $urandom, $urandom, $urandom}) &
                    127'({$urandom, $urandom, $urandom, $urandom}) &
                    127'({$urandom, $urandom, $urandom, $urandom});
                send(v, cyc);
            end
            wait_idle();
        end
        rand_rdy = 1'b0;
        out_ready_s = 1'b1;
    endtask

    task automatic test_flush();
        int cyc;
        sel = 0;
        out_ready_s = 1'b1;
        send(127'h100220, cyc);
        @(negedge clk);
        @(posedge clk);
        #1;
        out_ready_s = 1'b0;
        flush = 1'b1;
        in_valid_s = 1'b1;
        in_vec_s = 127'h2;
        @(negedge clk);
        n_checks++;
        if (obs_in_ready !== 1'b0) $display("FAIL flush_in_ready got=%b required=0", obs_in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid_s = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs_valid !== 1'b0 || obs_in_ready !== 1'b1)
            $display("FAIL flush_after got=vld%b_rdy%b required=vld0_rdy1", obs_valid, obs_in_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs_valid !== 1'b0) $display("FAIL flush_no_accept got=%b required=0", obs_valid);
        else n_pass++;
        exp_q.delete();
        @(posedge clk);
        #1;
        out_ready_s = 1'b1;
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        sel = 0;
        out_ready_s = 1'b0;
        send(127'h100220, cyc);
        @(negedge clk);
        n_checks++;
        if (obs_valid !== 1'b1) $display("FAIL rst_pre_valid got=%b required=1", obs_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_valid !== 1'b0) $display("FAIL rst_async_drop got=%b required=0", obs_valid);
        else n_pass++;
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs_valid !== 1'b0 || obs_in_ready !== 1'b1)
            $display("FAIL rst_after got=vld%b_rdy%b required=vld0_rdy1", obs_valid, obs_in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        out_ready_s = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lsb_first();
        test_zero();
        test_lanes();
        test_msb_hold();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
